compression_cpu_cpu_debug_jtag_host: RTL and testbench
======================================================

// Module: compression_cpu_cpu_debug_jtag_host
// PURPOSE
//  Host-side initiator for the Nios II debug-slave virtual-JTAG interface. Takes a command
//  (2-bit IR + 38-bit DR word), generates the matching virtual-JTAG state sequence
//  (UIR, CDR, SDR x DR_WIDTH, UDR, RTI) on a divided TCK and returns the 38 bits shifted out
//  on TDO. Used as an on-chip debug driver and as the bench stimulus for the debug slave.
// PARAMETERS
//  DR_WIDTH  38  data-register length in bits; must match the slave's sr width
//  IR_WIDTH  2   virtual IR width
//  TCK_DIV   2   clk cycles per TCK half-period; legal range >= 1
// PORTS
//  clk         in   1         system clock; all logic on rising edge
//  reset       in   1         synchronous, active-high reset
//  cmd_valid   in   1         command present
//  cmd_ready   out  1         command accepted when cmd_valid & cmd_ready
//  cmd_ir      in   IR_WIDTH  IR value presented to slave during UIR
//  cmd_dr      in   DR_WIDTH  word shifted into slave, LSB first
//  rsp_valid   out  1         response available; held until rsp_ready
//  rsp_ready   in   1         response consumed when rsp_valid & rsp_ready
//  rsp_dr      out  DR_WIDTH  bits captured from vji_tdo, first bit in [0]
//  rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled at the UIR rising TCK edge
//  vji_tck     out  1         generated TCK (registered)
//  vji_tdi     out  1         serial data to slave
//  vji_ir_in   out  IR_WIDTH  IR to slave; held from UIR until next command
//  vji_uir/vji_cdr/vji_sdr/vji_udr  out 1 each  virtual-state flags, one-hot or all-zero
//  vji_rti     out  1         run-test/idle flag
//  vji_tdo     in   1         serial data from slave
//  vji_ir_out  in   IR_WIDTH  IR readback from slave
// BEHAVIOUR
//  - Reset values: vji_tck=0, vji_tdi=0, vji_ir_in=0, uir/cdr/sdr/udr=0, vji_rti=1,
//    rsp_valid=0, rsp_dr=0, rsp_ir_out=0, cmd_ready=0 while reset is high. Reset wins over any
//    other event in the same cycle.
//  - cmd_ready = (state==IDLE) & !rsp_valid & !reset. In IDLE: TCK held low, rti=1.
//  - TCK period: TCK_DIV clk cycles low, then TCK_DIV clk cycles high. A period starts at the
//    falling edge (or on leaving IDLE).
//  - State flags and vji_tdi change only at a period start. vji_tdo and vji_ir_out are sampled
//    in the clk cycle where vji_tck goes 0->1.
//  - FSM: IDLE -> UIR(1 period) -> CDR(1) -> SDR(DR_WIDTH) -> UDR(1) -> RTI(1) -> IDLE.
//    Entry to IDLE sets rsp_valid.
//  - Acceptance at cycle t0 latches cmd_ir/cmd_dr. UIR starts at t0+1, and vji_ir_in=cmd_ir
//    from t0+1.
//  - SDR period k (k = 0 .. DR_WIDTH-1): vji_tdi = cmd_dr[k]. At the rising edge,
//    rx = {vji_tdo, rx[DR_WIDTH-1:1]}. After the last bit, rx[k] equals the k-th TDO bit.
//  - Bit counter is 6 bits wide, counts 0..DR_WIDTH-1 and leaves SDR on the terminal count.
//    The divider counter wraps at TCK_DIV-1.
//  - Latency: rsp_valid rises at t0+1+(DR_WIDTH+4)*2*TCK_DIV (t0+169 at defaults). rsp_dr and
//    rsp_ir_out are stable while rsp_valid is high.
//  - Handshake: a rsp_valid & rsp_ready cycle clears rsp_valid on the next clk.
//    cmd_valid is ignored while cmd_ready=0.
//  - Reset mid-sequence: the sequence aborts, the next cycle shows reset values, no UDR pulse
//    is issued and no response is produced.
//  - vji_tdi returns to 0 outside SDR.
// TESTING
//  1. Assert reset for 3 cycles, then release -> all outputs at reset values during reset;
//     cmd_ready=1 on the first cycle after release; TCK is static.
//  2. Slave model captures 38'h15_DEADBEEF at CDR. Send cmd ir=2'b01, dr=38'h2A_55555555 ->
//     model sees ir_in=1 at UIR and receives 38'h2A_55555555 at UDR;
//     rsp_dr=38'h15_DEADBEEF; rsp_valid at t0+169.
//  3. Hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_dr and rsp_ir_out stay
//     stable; cmd_ready=0; a pulsed cmd_valid is not accepted.
//  4. Assert reset during SDR bit 20 -> reset values on the next cycle; the slave model sees
//     no UDR; no rsp_valid; a fresh command afterwards completes normally.
//  5. Build with TCK_DIV=1 -> TCK period is 2 clk; rsp_valid at t0+85; data is still correct.
//  6. Hold cmd_valid and rsp_ready at 1 over two commands -> second accepted exactly one cycle
//     after the first response handshake; vji_ir_in switches only at the second UIR.

Source files
------------

// File: rtl/compression_cpu_cpu_debug_jtag_host.sv
// Host-side virtual-JTAG initiator for the debug slave.
// Runs UIR/CDR/SDR/UDR/RTI on a divided TCK and returns shifted-out TDO bits.
module compression_cpu_cpu_debug_jtag_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);

  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, UIR, CDR, SDR, UDR, RTI
  } state_t;

  state_t              state;
  logic [DW-1:0]       div;
  logic [5:0]          bit_cnt;
  logic [DR_WIDTH-1:0] tx;
  logic                half_end;
  logic                rise;
  logic                fall;

  assign half_end  = (div == DIV_LAST);
  assign rise      = half_end & ~vji_tck;
  assign fall      = half_end & vji_tck;
  assign cmd_ready = (state == IDLE) & ~rsp_valid & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      tx         <= '0;
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b1;
    end else begin
      if (rsp_valid && rsp_ready)
        rsp_valid <= 1'b0;
      if (state == IDLE) begin
        vji_tck <= 1'b0;
        div     <= '0;
        if (cmd_valid && cmd_ready) begin
          state     <= UIR;
          tx        <= cmd_dr;
          vji_ir_in <= cmd_ir;
          vji_uir   <= 1'b1;
          vji_rti   <= 1'b0;
        end
      end else begin
        div <= half_end ? '0 : div + 1'b1;
        if (rise) begin
          vji_tck <= 1'b1;
          if (state == UIR)
            rsp_ir_out <= vji_ir_out;
          if (state == SDR)
            rsp_dr <= {vji_tdo, rsp_dr[DR_WIDTH-1:1]};
        end
        // Falling edge closes one TCK period and advances the sequence.
        if (fall) begin
          vji_tck <= 1'b0;
          unique case (state)
            UIR: begin
              state   <= CDR;
              vji_uir <= 1'b0;
              vji_cdr <= 1'b1;
            end
            CDR: begin
              state   <= SDR;
              vji_cdr <= 1'b0;
              vji_sdr <= 1'b1;
              bit_cnt <= '0;
              vji_tdi <= tx[0];
              tx      <= {1'b0, tx[DR_WIDTH-1:1]};
            end
            SDR: begin
              if (bit_cnt == BIT_LAST) begin
                state   <= UDR;
                vji_sdr <= 1'b0;
                vji_udr <= 1'b1;
                vji_tdi <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
                vji_tdi <= tx[0];
                tx      <= {1'b0, tx[DR_WIDTH-1:1]};
              end
            end
            UDR: begin
              state   <= RTI;
              vji_udr <= 1'b0;
              vji_rti <= 1'b1;
            end
            RTI: begin
              state     <= IDLE;
              rsp_valid <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_compression_cpu_cpu_debug_jtag_host.sv
// Bench: two hosts (TCK_DIV 2 and 1) each driving a behavioural
// virtual-JTAG slave; results checked against spec-level expectations.
module tb_compression_cpu_cpu_debug_jtag_host;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [1:0]       cmd_valid = '0;
  logic [1:0]       cmd_ready;
  logic [1:0][1:0]  cmd_ir = '0;
  logic [1:0][37:0] cmd_dr = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [1:0][37:0] rsp_dr;
  logic [1:0][1:0]  rsp_ir_out;
  logic [1:0]       vji_tck, vji_tdi, vji_tdo;
  logic [1:0][1:0]  vji_ir_in;
  logic [1:0][1:0]  vji_ir_out = '0;
  logic [1:0]       uir, cdr, sdr, udr, rti;

  logic [1:0][37:0] s_cap = '0;
  logic [1:0][37:0] s_got;
  logic [1:0][1:0]  s_ir;
  logic [1:0][7:0]  s_udr_n;

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : ch
    compression_cpu_cpu_debug_jtag_host #(
      .DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(g == 0 ? 2 : 1)
    ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_ir(cmd_ir[g]), .cmd_dr(cmd_dr[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_dr(rsp_dr[g]), .rsp_ir_out(rsp_ir_out[g]),
      .vji_tck(vji_tck[g]), .vji_tdi(vji_tdi[g]),
      .vji_ir_in(vji_ir_in[g]),
      .vji_uir(uir[g]), .vji_cdr(cdr[g]),
      .vji_sdr(sdr[g]), .vji_udr(udr[g]),
      .vji_rti(rti[g]),
      .vji_tdo(vji_tdo[g]), .vji_ir_out(vji_ir_out[g])
    );

    // Behavioural slave: everything happens on rising TCK.
    logic [37:0] sr = '0;
    logic [37:0] got = '0;
    logic [1:0]  irs = '0;
    logic [7:0]  nudr = '0;
    always @(posedge vji_tck[g]) begin
      if (uir[g]) irs <= vji_ir_in[g];
      if (cdr[g]) sr <= s_cap[g];
      else if (sdr[g]) sr <= {vji_tdi[g], sr[37:1]};
      if (udr[g]) begin
        got  <= sr;
        nudr <= nudr + 8'd1;
      end
    end
    assign vji_tdo[g] = sr[0];
    assign s_got[g]   = got;
    assign s_ir[g]    = irs;
    assign s_udr_n[g] = nudr;
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        if ($countones({uir[c], cdr[c], sdr[c], udr[c]}) > 1) viol++;
        if (vji_tdi[c] && !sdr[c]) viol++;
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_rst(int c);
    chk("rst_flags",
        {vji_tck[c], vji_tdi[c], vji_ir_in[c], uir[c], cdr[c],
         sdr[c], udr[c], rti[c], rsp_valid[c], cmd_ready[c]},
        {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("rst_rsp_dr", rsp_dr[c], 0);
    chk("rst_rsp_ir", rsp_ir_out[c], 0);
  endtask

  function automatic int lat_of(int c);
    return 1 + (38 + 4) * 2 * (c == 0 ? 2 : 1);
  endfunction

  // Issue one command from a negedge and wait for its response.
  task automatic run_cmd(int c, logic [1:0] ir, logic [37:0] dr,
                         logic [37:0] cap, logic [1:0] iro);
    int n;
    logic [7:0] u0;
    s_cap[c] = cap;
    vji_ir_out[c] = iro;
    u0 = s_udr_n[c];
    n = 0;
    while (!cmd_ready[c] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", cmd_ready[c], 1);
    cmd_valid[c] = 1'b1;
    cmd_ir[c] = ir;
    cmd_dr[c] = dr;
    @(negedge clk);
    cmd_valid[c] = 1'b0;
    n = 1;
    chk("uir_start", {uir[c], vji_ir_in[c]}, {1'b1, ir});
    while (!rsp_valid[c] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat_of(c));
    chk("rsp_dr", rsp_dr[c], cap);
    chk("rsp_ir_out", rsp_ir_out[c], iro);
    chk("slave_dr", s_got[c], dr);
    chk("slave_ir", s_ir[c], ir);
    chk("udr_count", 8'(s_udr_n[c] - u0), 1);
  endtask

  task automatic consume(int c);
    rsp_ready[c] = 1'b1;
    @(negedge clk);
    rsp_ready[c] = 1'b0;
    chk("rsp_cleared", rsp_valid[c], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    logic [7:0]  u0;
    logic [37:0] hd;
    logic [1:0]  hi;

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_rst(0);
      chk_rst(1);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 2'b11);
    chk("tck_idle", vji_tck, 2'b00);

    // Directed command on both divider settings.
    run_cmd(0, 2'b01, 38'h2A_55555555, 38'h15_DEADBEEF, 2'b10);
    consume(0);
    run_cmd(1, 2'b01, 38'h2A_55555555, 38'h15_DEADBEEF, 2'b11);
    consume(1);

    // Response held back: everything must stay put, commands ignored.
    run_cmd(0, 2'b11, 38'h01_23456789, 38'h3F_0F0F0F0F, 2'b01);
    hd = rsp_dr[0];
    hi = rsp_ir_out[0];
    for (int i = 0; i < 10; i++) begin
      cmd_valid[0] = (i == 4);
      @(negedge clk);
      chk("hold_valid", rsp_valid[0], 1);
      chk("hold_dr", rsp_dr[0], hd);
      chk("hold_ir", rsp_ir_out[0], hi);
      chk("hold_ready", cmd_ready[0], 0);
    end
    cmd_valid[0] = 1'b0;
    consume(0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (uir[0]) seen++;
    end
    chk("no_stray_cmd", seen, 0);

    // Reset in the middle of SDR bit 20.
    u0 = s_udr_n[0];
    cmd_valid[0] = 1'b1;
    cmd_ir[0] = 2'b10;
    cmd_dr[0] = 38'h00_FFFF0000;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    n = 1;
    while (n < 90) begin
      @(negedge clk);
      n++;
    end
    chk("in_sdr", sdr[0], 1);
    reset = 1'b1;
    @(negedge clk);
    chk_rst(0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    chk("abort_no_udr", s_udr_n[0], u0);
    run_cmd(0, 2'b10, 38'h12_3456789A, 38'h0B_CAFEF00D, 2'b01);
    consume(0);

    // Back-to-back commands with valid and ready held high.
    s_cap[0] = 38'h2B_ADC0FFEE;
    vji_ir_out[0] = 2'b00;
    rsp_ready[0] = 1'b1;
    cmd_valid[0] = 1'b1;
    cmd_ir[0] = 2'b10;
    cmd_dr[0] = 38'h11_11111111;
    n = 0;
    while (!cmd_ready[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_ir[0] = 2'b11;
    cmd_dr[0] = 38'h22_22222222;
    n = 1;
    while (!rsp_valid[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", n, lat_of(0));
    chk("b2b_first_dr", s_got[0], 38'h11_11111111);
    @(negedge clk);
    chk("b2b_accept", cmd_ready[0], 1);
    chk("b2b_ir_held", {uir[0], vji_ir_in[0]}, {1'b0, 2'b10});
    @(negedge clk);
    chk("b2b_ir_switch", {uir[0], vji_ir_in[0]}, {1'b1, 2'b11});
    n = 2;
    while (!rsp_valid[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cmd_valid[0] = 1'b0;
    chk("b2b_second_lat", n, lat_of(0) + 1);
    chk("b2b_second_dr", s_got[0], 38'h22_22222222);
    chk("b2b_second_rsp", rsp_dr[0], 38'h2B_ADC0FFEE);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    chk("b2b_done", rsp_valid[0], 0);

    // Randomized commands on both hosts.
    for (int i = 0; i < 8; i++) begin
      int c;
      c = i % 2;
      run_cmd(c, 2'($urandom), 38'({$urandom, $urandom}),
              38'({$urandom, $urandom}), 2'($urandom));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      consume(c);
    end

    chk("flag_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
